// File: rtl/msb_pkg.sv
// -----------------------------------------------------------------------------
// msb_pkg
// Shared definitions for the multi-stream buffer read path.
//   - default buffer geometry (ways, channels, streams, lines, lengths, credits)
//   - pointer types: stream id, cache line, way offset, and the {cl, of} pointer
//   - read-request sequencer FSM state encoding
//   - ptr_advance(): steps a head pointer by one 16 B beat
// -----------------------------------------------------------------------------
package msb_pkg;

   localparam int MSB_WAYS      = 8;   // 8 B BRAM ways per cache line
   localparam int MSB_CHANNELS  = 2;   // L2 write channels
   localparam int MSB_NSTRMS    = 32;  // total streams
   localparam int MSB_L1_NCL    = 16;  // cache lines per stream
   localparam int MSB_LEN_WIDTH = 8;   // command beat-count width
   localparam int MSB_MAX_OUT   = 4;   // maximum in-flight read requests

   localparam int MSB_WAYS_WIDTH   = $clog2(MSB_WAYS);
   localparam int MSB_L1_NCL_WIDTH = $clog2(MSB_L1_NCL);
   localparam int MSB_STRM_WIDTH   = $clog2(MSB_NSTRMS);

   // One beat moves 16 B, i.e. two 8 B ways.
   localparam int BEAT_WAYS = 2;

   typedef logic [MSB_STRM_WIDTH-1:0]   strm_id_t;
   typedef logic [MSB_L1_NCL_WIDTH-1:0] cl_t;
   typedef logic [MSB_WAYS_WIDTH-1:0]   of_t;

   typedef struct packed {
      cl_t cl;
      of_t of;
   } ptr_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } seq_state_t;

   // Advance a head pointer by one beat. The offset wraps within the line;
   // on wrap the line index steps, itself wrapping after the last line.
   function automatic ptr_t ptr_advance(input ptr_t p);
      ptr_t n;
      n.of = p.of + of_t'(BEAT_WAYS);
      n.cl = p.cl;
      if (n.of == '0) begin
         n.cl = (p.cl == cl_t'(MSB_L1_NCL - 1)) ? '0 : p.cl + cl_t'(1);
      end
      return n;
   endfunction

endpackage

// File: rtl/msb_ptr_table.sv
// -----------------------------------------------------------------------------
// msb_ptr_table
// Per-stream head-pointer store held in flops (one ptr_t per stream).
// Ports:
//   clk1x, reset       : clock, asynchronous active-high reset (all entries 0)
//   rd_idx / rd_ptr    : combinational read port
//   wr_en/wr_idx/wr_ptr: write port (pointer writeback at end of a command)
//   clr_en/clr_idx     : clear port, zeroes an entry; wins over a same-entry write
// -----------------------------------------------------------------------------
module msb_ptr_table
   import msb_pkg::*;
#(
   parameter int NENT = MSB_NSTRMS
)(
   input  logic     clk1x,
   input  logic     reset,
   input  strm_id_t rd_idx,
   output ptr_t     rd_ptr,
   input  logic     wr_en,
   input  strm_id_t wr_idx,
   input  ptr_t     wr_ptr,
   input  logic     clr_en,
   input  strm_id_t clr_idx
);

   ptr_t tab_reg [NENT];

   // Each entry has its own enable decode so clear and write can target
   // different entries in the same cycle.
   for (genvar gi = 0; gi < NENT; gi++) begin : g_ent
      always_ff @(posedge clk1x or posedge reset) begin
         if (reset) begin
            tab_reg[gi] <= '0;
         end else if (clr_en && (clr_idx == strm_id_t'(gi))) begin
            tab_reg[gi] <= '0;
         end else if (wr_en && (wr_idx == strm_id_t'(gi))) begin
            tab_reg[gi] <= wr_ptr;
         end
      end
   end

   assign rd_ptr = tab_reg[rd_idx];

endmodule

// File: rtl/msb_rd_req_seq.sv
// -----------------------------------------------------------------------------
// msb_rd_req_seq
// Per-port read-request sequencer for the multi-stream buffer. Accepts
// "stream S, N beats" commands, walks that stream's head pointer one 16 B beat
// per request, and throttles issue against a count of outstanding responses.
// Ports:
//   clk1x, reset          : single clock, asynchronous active-high reset
//   cmd_v/cmd_r           : command handshake; cmd_strm global stream, cmd_len beats
//   clr_v/clr_strm        : zero a stream's stored head pointer
//   q_v/q_r               : request handshake toward the BRAM read port
//   q_ra_ch/st/cl/of      : request address (channel, local stream, line, way offset)
//   rsp_done              : one read response consumed (returns a credit)
//   busy                  : a command is being issued
// -----------------------------------------------------------------------------
module msb_rd_req_seq
   import msb_pkg::*;
#(
   parameter  int WAYS            = MSB_WAYS,
   parameter  int channels        = MSB_CHANNELS,
   parameter  int nstrms          = MSB_NSTRMS,
   parameter  int l1_ncl          = MSB_L1_NCL,
   parameter  int LEN_WIDTH       = MSB_LEN_WIDTH,
   parameter  int MAX_OUT         = MSB_MAX_OUT,
   localparam int WAYS_WIDTH      = $clog2(WAYS),
   localparam int channels_width  = $clog2(channels),
   localparam int l1_nstrms       = nstrms / channels,
   localparam int l1_nstrms_width = $clog2(l1_nstrms),
   localparam int l1_ncl_width    = $clog2(l1_ncl),
   localparam int strm_width      = $clog2(nstrms)
)(
   input  logic                       clk1x,
   input  logic                       reset,
   input  logic                       cmd_v,
   output logic                       cmd_r,
   input  logic [strm_width-1:0]      cmd_strm,
   input  logic [LEN_WIDTH-1:0]       cmd_len,
   input  logic                       clr_v,
   input  logic [strm_width-1:0]      clr_strm,
   output logic                       q_v,
   input  logic                       q_r,
   output logic [channels_width-1:0]  q_ra_ch,
   output logic [l1_nstrms_width-1:0] q_ra_st,
   output logic [l1_ncl_width-1:0]    q_ra_cl,
   output logic [WAYS_WIDTH-1:0]      q_ra_of,
   input  logic                       rsp_done,
   output logic                       busy
);

   // The pointer types come from msb_pkg, so the geometry parameters here are
   // expected to match the package defaults.
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0]     MAX_OUT_C = CNT_W'(MAX_OUT);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

   seq_state_t            state_reg,   state_next;
   strm_id_t              strm_reg,    strm_next;
   logic [LEN_WIDTH-1:0]  rem_reg,     rem_next;
   ptr_t                  wptr_reg,    wptr_next;
   logic [CNT_W-1:0]      out_cnt_reg, out_cnt_next;

   ptr_t tab_rd_ptr;
   ptr_t wptr_adv;
   logic tab_wr_en;
   logic q_fire;
   logic cnt_inc;
   logic cnt_dec;

   msb_ptr_table #(
      .NENT (nstrms)
   ) u_ptr_table (
      .clk1x   (clk1x),
      .reset   (reset),
      .rd_idx  (strm_id_t'(cmd_strm)),
      .rd_ptr  (tab_rd_ptr),
      .wr_en   (tab_wr_en),
      .wr_idx  (strm_reg),
      .wr_ptr  (wptr_adv),
      .clr_en  (clr_v),
      .clr_idx (strm_id_t'(clr_strm))
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk1x or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         strm_reg    <= '0;
         rem_reg     <= '0;
         wptr_reg    <= '0;
         out_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         strm_reg    <= strm_next;
         rem_reg     <= rem_next;
         wptr_reg    <= wptr_next;
         out_cnt_reg <= out_cnt_next;
      end
   end

   // Request outputs depend only on registered state, never on q_r, so the
   // address holds steady while the port back-pressures.
   assign q_v     = (state_reg == ST_ISSUE) && (out_cnt_reg < MAX_OUT_C);
   assign q_fire  = q_v && q_r;
   assign busy    = (state_reg == ST_ISSUE);
   assign q_ra_ch = strm_reg[strm_width-1 -: channels_width];
   assign q_ra_st = strm_reg[l1_nstrms_width-1:0];
   assign q_ra_cl = wptr_reg.cl;
   assign q_ra_of = wptr_reg.of;

   assign wptr_adv = ptr_advance(wptr_reg);

   // ------------------------------------------------- next state / outputs
   always_comb begin
      state_next = state_reg;
      strm_next  = strm_reg;
      rem_next   = rem_reg;
      wptr_next  = wptr_reg;
      cmd_r      = 1'b0;
      tab_wr_en  = 1'b0;

      unique case (state_reg)
         ST_IDLE: begin
            cmd_r = 1'b1;
            // A zero-length command is consumed here without touching anything.
            if (cmd_v && (cmd_len != '0)) begin
               state_next = ST_ISSUE;
               strm_next  = strm_id_t'(cmd_strm);
               rem_next   = cmd_len;
               wptr_next  = tab_rd_ptr;
            end
         end
         ST_ISSUE: begin
            if (q_fire) begin
               wptr_next = wptr_adv;
               rem_next  = rem_reg - LEN_ONE;
               if (rem_reg == LEN_ONE) begin
                  // Last beat: store the already-advanced pointer so the next
                  // command on this stream resumes after it.
                  tab_wr_en  = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- credits
   // A response with nothing outstanding is spurious and dropped; an issue
   // and a valid response in the same cycle cancel out.
   assign cnt_inc = q_fire;
   assign cnt_dec = rsp_done && (out_cnt_reg != '0);

   always_comb begin
      out_cnt_next = out_cnt_reg;
      unique case ({cnt_inc, cnt_dec})
         2'b10:   out_cnt_next = out_cnt_reg + CNT_W'(1);
         2'b01:   out_cnt_next = out_cnt_reg - CNT_W'(1);
         default: out_cnt_next = out_cnt_reg;
      endcase
   end

endmodule

// File: doc/msb_rd_req_seq.md
# msb_rd_req_seq

Per-port read-request sequencer for the multi-stream buffer. It sits directly upstream of one read port of the L1 BRAM array. It accepts stream read commands of the form "global stream S, N beats" and keeps a head pointer (cache line, way offset) for every stream. It issues one 16 B read request per beat, split into channel, stream, cache line and offset fields, and throttles issue against a credit count of responses not yet consumed.

## Interface
- `WAYS`, 8: BRAMs (8 B ways) per cache line.
- `channels`, 2: L2 write channels.
- `nstrms`, 32: total streams.
- `l1_ncl`, 16: cache lines per stream.
- `LEN_WIDTH`, 8: command beat-count width.
- `MAX_OUT`, 4: maximum in-flight requests.
- Derived: `WAYS_WIDTH`, `channels_width`, `l1_nstrms` = nstrms/channels, `l1_nstrms_width`, `l1_ncl_width`, `strm_width` = $clog2(nstrms).
- `clk1x` input 1: the single clock. The block has one clock.
- `reset` input 1: asynchronous, active-high reset.
- `cmd_v` input 1, `cmd_r` output 1: command handshake.
- `cmd_strm` input strm_width: global stream id.
- `cmd_len` input LEN_WIDTH: number of beats.
- `clr_v` input 1, `clr_strm` input strm_width: reset that stream's head pointer to 0.
- `q_v` output 1, `q_r` input 1: request handshake toward the BRAM port's `i_v`/`i_r`.
- `q_ra_ch` output channels_width, `q_ra_st` output l1_nstrms_width, `q_ra_cl` output l1_ncl_width, `q_ra_of` output WAYS_WIDTH: request address.
- `rsp_done` input 1: pulse when the port's read response is consumed (`o_v & o_r`).
- `busy` output 1: a command is active.

## Operation
- Pointer table: nstrms entries of {cl, of}, held in flops. All entries are 0 at reset.
- Stream id split: ch = cmd_strm[MSBs of width channels_width], st = cmd_strm[l1_nstrms_width-1:0].
- FSM states are IDLE and ISSUE.
  - IDLE: `cmd_r`=1. On `cmd_v`:
    - If cmd_len≠0, latch the stream, latch rem=cmd_len, load the working pointer from the table, and go to ISSUE.
    - If cmd_len=0, accept the command, issue nothing, leave the pointer unchanged, and stay in IDLE.
  - ISSUE: `cmd_r`=0. `q_v` = (out_cnt < MAX_OUT). The address is the working pointer.
  - On `q_v & q_r`:
    - of += 2 (one beat = two ways = 16 B).
    - When of wraps to 0, cl += 1 modulo l1_ncl, so cl 15 of 6 is followed by cl 0 of 0.
    - rem -= 1.
    - On the last beat (rem=1), write the advanced pointer back to the table and go to IDLE.
- Credits: out_cnt increments on `q_v & q_r` and decrements on `rsp_done`.
  - If both occur in the same cycle, out_cnt is unchanged.
  - `rsp_done` with out_cnt=0 is ignored.
  - The counter width is $clog2(MAX_OUT+1).
- Clear: `clr_v` writes 0 to table[clr_strm] in any state.
  - A clear takes priority over a same-cycle writeback to the same entry.
  - A clear of the active stream does not alter the in-progress working pointer.
- `busy` = (state==ISSUE).

## Timing
- Reset values: `cmd_r`=1, `q_v`=0, all `q_ra_*`=0, `busy`=0. out_cnt, rem, working pointer and table are all 0.
- Reset asserted mid-command returns the block to IDLE asynchronously. `q_v` drops at once and all pointers are lost.
- A command accepted at edge N gives its first `q_v` in cycle N+1.
- With `q_r`=1 and credits available, the block issues one beat per cycle. A command of N beats occupies cycles N+1..N+N.
- After the last beat handshake, `cmd_r` is 1 in the next cycle. The back-to-back command gap is one cycle.
- `q_v` and `q_ra_*` come from registers only; there is no combinational path from `q_r`. While `q_v`=1 and `q_r`=0, the address is held stable.
- A `rsp_done` at edge M can re-enable `q_v` in cycle M+1.
- A pointer written back at edge M is visible to a command accepted at edge M+1 or later.

## Structure
- Shared package `msb_pkg` holds:
  - the typedefs `strm_id_t`, `cl_t`, `of_t`, and `ptr_t` = {cl_t, of_t};
  - the FSM state enum;
  - the constant `BEAT_WAYS` = 2.
- Sub-module `msb_ptr_table`: nstrms×ptr_t flop array. It has one combinational read port, one write port, and one clear port with clear priority.

## Test plan
- Reset, then cmd stream 0 len 3, with `q_r`=1 and a `rsp_done` each cycle:
  - beats are (ch0, st0, cl0, of0), (0, 0, 0, 2), (0, 0, 0, 4);
  - table[0] ends at cl0 of6;
  - `busy` is high for 3 cycles.
- cmd stream 17 len 5:
  - beats are (ch1, st1) cl0 of0, of2, of4, of6, then cl1 of0;
  - table[17] ends at cl1 of2.
- Wrap: drive stream 2 to cl15 of6 (63 beats), then issue len 2:
  - beats are cl15 of6, then cl0 of0;
  - table[2] ends at cl0 of2.
- Credits: MAX_OUT=4, no `rsp_done`, len 6:
  - exactly 4 beats issue, then `q_v`=0 indefinitely;
  - one `rsp_done` pulse gives exactly one further beat in the next cycle.
- Simultaneous events:
  - `clr_v` on the active stream in the cycle of its last beat leaves the table entry at 0;
  - `q_r` held low for 3 cycles keeps the address stable;
  - reset asserted mid-command gives `q_v`=0 immediately and table entries of 0.
- cmd_len=0 on stream 5: accepted in one cycle, no `q_v`, table[5] unchanged.
